// File: rtl/inference_scheduler_if.sv
// Byte, image-buffer and BNN signals of the inference scheduler.
// master: scheduler side; slave: SPI/buffer/BNN side.
interface inference_scheduler_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_taken;
  logic       wr_req;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic [6:0] wr_addr;
  logic       buf_full;
  logic       bnn_enable;
  logic       result_ready;
  logic [3:0] result_in;
  logic       clear;
  logic [3:0] result_out;
  logic       result_valid;
  logic       timeout_err;
  logic [3:0] status;

  modport master (
    input  rx_byte, rx_valid, wr_ready,
    input  buf_full, result_ready, result_in,
    output rx_taken, wr_req, wr_data, wr_addr,
    output bnn_enable, clear, result_out,
    output result_valid, timeout_err, status
  );

  modport slave (
    output rx_byte, rx_valid, wr_ready,
    output buf_full, result_ready, result_in,
    input  rx_taken, wr_req, wr_data, wr_addr,
    input  bnn_enable, clear, result_out,
    input  result_valid, timeout_err, status
  );
endinterface

// File: rtl/inference_scheduler.sv
// Sequences one OCR inference: command decode, pixel load,
// BNN run under a watchdog, result latch.
module inference_scheduler #(
  parameter int         IMG_BYTES      = 113,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] CMD_LOAD       = 8'hB0,
  parameter logic [7:0] CMD_CLEAR      = 8'hC1
) (
  input logic clk,
  input logic rst_n,
  inference_scheduler_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0] LAST = 7'(IMG_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_FILL,
    S_WAIT, S_DONE, S_ERR, S_CLEAR
  } state_t;

  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [6:0] count;
  logic err_load;
  logic rx_taken_q;
  logic [7:0] wr_data_q;
  logic [6:0] wr_addr_q;
  logic [3:0] result_q;
  logic valid_q;
  logic terr_q;

  logic accept, expired;
  logic take, cap, cnt_inc, cnt_clr;
  logic latch, err_set, err_is_load;

  // A byte being acknowledged is still on rx_valid; never take it twice.
  assign accept  = bus.rx_valid && !rx_taken_q;
  assign expired = (timer == T_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    take        = 1'b0;
    cap         = 1'b0;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    latch       = 1'b0;
    err_set     = 1'b0;
    err_is_load = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          take = 1'b1;
          if (bus.rx_byte == CMD_LOAD) begin
            state_n = S_LOAD;
            cnt_clr = 1'b1;
          end else if (bus.rx_byte == CMD_CLEAR) begin
            state_n = S_CLEAR;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          take    = 1'b1;
          cap     = 1'b1;
          state_n = S_WRITE;
        end else if (expired) begin
          state_n     = S_ERR;
          err_set     = 1'b1;
          err_is_load = 1'b1;
        end
      end
      S_WRITE: begin
        if (bus.wr_ready) begin
          if (count == LAST) begin
            state_n = S_FILL;
          end else begin
            state_n = S_LOAD;
            cnt_inc = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (bus.buf_full) begin
          state_n = S_WAIT;
        end else if (expired) begin
          state_n = S_ERR;
          err_set = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.result_ready) begin
          state_n = S_DONE;
          latch   = 1'b1;
        end else if (expired) begin
          state_n = S_ERR;
          err_set = 1'b1;
        end
      end
      S_DONE, S_ERR: begin
        if (accept) begin
          take = 1'b1;
          if (bus.rx_byte == CMD_CLEAR)
            state_n = S_CLEAR;
        end
      end
      S_CLEAR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state_n != state) begin
      timer <= '0;
    end else if ((state == S_LOAD || state == S_FILL ||
                  state == S_WAIT) && !expired) begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      err_load   <= 1'b0;
      rx_taken_q <= 1'b0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      rx_taken_q <= take;
      if (cap) begin
        wr_data_q <= bus.rx_byte;
        wr_addr_q <= count;
      end
      if (cnt_clr || state == S_CLEAR) count <= '0;
      else if (cnt_inc)                count <= count + 1'b1;
      if (latch) begin
        result_q <= bus.result_in;
        valid_q  <= 1'b1;
      end
      if (err_set) begin
        terr_q   <= 1'b1;
        valid_q  <= 1'b0;
        err_load <= err_is_load;
      end
      if (state == S_CLEAR) begin
        terr_q  <= 1'b0;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_taken     = rx_taken_q;
  assign bus.wr_req       = (state == S_WRITE);
  assign bus.wr_data      = wr_data_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.bnn_enable   = (state == S_WAIT);
  assign bus.clear        = (state == S_CLEAR);
  assign bus.result_out   = result_q;
  assign bus.result_valid = valid_q;
  assign bus.timeout_err  = terr_q;

  always_comb begin
    bus.status = 4'd0;
    unique case (state)
      S_IDLE:  bus.status = 4'd0;
      S_LOAD:  bus.status = 4'd1;
      S_WRITE: bus.status = 4'd1;
      S_FILL:  bus.status = 4'd2;
      S_WAIT:  bus.status = 4'd2;
      S_DONE:  bus.status = 4'd3;
      S_ERR:   bus.status = err_load ? 4'd5 : 4'd4;
      S_CLEAR: bus.status = 4'd6;
      default: bus.status = 4'd0;
    endcase
  end
endmodule

// File: tb/tb_inference_scheduler.sv
// Directed bench for inference_scheduler: loads, stalls,
// watchdog expiries, DONE/ERR command handling, async reset.
module tb_inference_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  inference_scheduler_if bus ();

  inference_scheduler dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int wr_idx = 0;
  int cyc = 0;
  bit stall = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [6:0] prev_addr = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {3'b0, bus.rx_taken, bus.wr_req,
            bus.wr_data, bus.wr_addr, bus.bnn_enable,
            bus.clear, bus.result_out, bus.result_valid,
            bus.timeout_err, bus.status};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wr_ready: always 1, or 1 every third cycle when stalling
  always @(posedge clk) begin
    #1;
    cyc++;
    bus.wr_ready = stall ? (cyc % 3 == 0) : 1'b1;
  end

  // Write monitor: in-order addresses/data, stable while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold",
            {bus.wr_req, bus.wr_data, bus.wr_addr},
            {1'b1, prev_data, prev_addr});
      if (bus.wr_req && bus.wr_ready) begin
        chk("wr_addr", bus.wr_addr, wr_idx[6:0]);
        chk("wr_data", bus.wr_data, wr_idx[7:0]);
        wr_idx++;
      end
      prev_stall = bus.wr_req && !bus.wr_ready;
      prev_data  = bus.wr_data;
      prev_addr  = bus.wr_addr;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = bus.rx_taken;
    end
    bus.rx_valid = 1'b0;
    chk("rx_taken", got, 1);
  endtask

  task automatic load_full();
    wr_idx = 0;
    send_byte(8'hB0);
    for (int i = 0; i < 113; i++) send_byte(i[7:0]);
    repeat (4) step();
    chk("write_count", wr_idx, 113);
    chk("fill_status", bus.status, 2);
    chk("fill_bnn_off", bus.bnn_enable, 0);
  endtask

  task automatic wait_bnn();
    bus.buf_full = 1'b1;
    for (int i = 0; i < 10 && !bus.bnn_enable; i++)
      step();
    chk("bnn_rise", bus.bnn_enable, 1);
    chk("wait_status", bus.status, 2);
  endtask

  task automatic clear_seq();
    send_byte(8'hC1);
    chk("clear_pulse", bus.clear, 1);
    chk("clear_status", bus.status, 6);
    step();
    chk("clear_drop", bus.clear, 0);
    chk("idle_status", bus.status, 0);
    chk("idle_valid", bus.result_valid, 0);
    chk("idle_terr", bus.timeout_err, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.rx_byte      = '0;
    bus.rx_valid     = 1'b0;
    bus.wr_ready     = 1'b1;
    bus.buf_full     = 1'b0;
    bus.result_ready = 1'b0;
    bus.result_in    = '0;
    #2 rst_n = 1'b0;
    #1 chk("reset_outs", outs(), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_reset_outs", outs(), 0);

    // Unknown byte in IDLE is dropped
    send_byte(8'h55);
    step();
    chk("idle_drop", bus.status, 0);

    // Full load, result 7
    load_full();
    wait_bnn();
    chk("wait_valid_lo", bus.result_valid, 0);
    bus.result_in    = 4'd7;
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    bus.buf_full     = 1'b0;
    chk("done_status", bus.status, 3);
    chk("done_result", bus.result_out, 7);
    chk("done_valid", bus.result_valid, 1);
    chk("done_bnn_off", bus.bnn_enable, 0);

    // B0 in DONE is consumed and ignored
    send_byte(8'hB0);
    step();
    chk("done_b0_status", bus.status, 3);
    chk("done_b0_valid", bus.result_valid, 1);
    clear_seq();
    chk("clear_keeps_res", bus.result_out, 7);

    // Stalled load, then BNN never answers
    stall = 1'b1;
    load_full();
    stall = 1'b0;
    wait_bnn();
    repeat (4095) step();
    chk("wait_pre_expiry", bus.status, 2);
    step();
    bus.buf_full = 1'b0;
    chk("wait_to_status", bus.status, 4);
    chk("wait_to_bnn", bus.bnn_enable, 0);
    chk("wait_to_terr", bus.timeout_err, 1);
    chk("wait_to_valid", bus.result_valid, 0);
    clear_seq();

    // Stop after 50 pixel bytes
    wr_idx = 0;
    send_byte(8'hB0);
    for (int i = 0; i < 50; i++) send_byte(i[7:0]);
    repeat (4096) step();
    chk("load_pre_expiry", bus.status, 1);
    step();
    chk("load_to_status", bus.status, 5);
    chk("load_to_terr", bus.timeout_err, 1);
    send_byte(8'h12);
    step();
    chk("err_drop", bus.status, 5);
    clear_seq();

    // Result arrives on the expiry cycle
    load_full();
    wait_bnn();
    repeat (4095) step();
    chk("coin_pre", bus.status, 2);
    bus.result_in    = 4'd9;
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    bus.buf_full     = 1'b0;
    chk("coin_status", bus.status, 3);
    chk("coin_result", bus.result_out, 9);
    chk("coin_valid", bus.result_valid, 1);
    chk("coin_terr", bus.timeout_err, 0);
    clear_seq();

    // Async reset mid-load, then a clean reload
    wr_idx = 0;
    send_byte(8'hB0);
    for (int i = 0; i < 60; i++) send_byte(i[7:0]);
    rst_n = 1'b0;
    #1 chk("midload_reset", outs(), 0);
    step();
    rst_n = 1'b1;
    step();
    load_full();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
